// File: rtl/seg_display_driver.sv
// Converts a binary word (signed or unsigned) to three decimal digits plus a sign
// on four active-low 7-segment displays, using a serial double-dabble converter.
module seg_display_driver #(
    parameter int WORD_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] value,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic [6:0]        disp0,
    output logic [6:0]        disp1,
    output logic [6:0]        disp2,
    output logic [6:0]        disp3
);

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    state_t             r_state;
    logic [WORD_W:0]    r_mag;
    logic [11:0]        r_bcd;
    logic [CNT_W-1:0]   r_bitCount;
    logic               r_sign;
    logic               r_busy;
    logic               r_done;
    logic [6:0]         r_disp0;
    logic [6:0]         r_disp1;
    logic [6:0]         r_disp2;
    logic [6:0]         r_disp3;

    logic               w_negative;
    logic [WORD_W:0]    w_magWide;
    logic [11:0]        w_adjBcd;

    function automatic logic [6:0] segCode(input logic [3:0] digit);
        case (digit)
            4'd0:    segCode = 7'h40;
            4'd1:    segCode = 7'h79;
            4'd2:    segCode = 7'h24;
            4'd3:    segCode = 7'h30;
            4'd4:    segCode = 7'h19;
            4'd5:    segCode = 7'h12;
            4'd6:    segCode = 7'h02;
            4'd7:    segCode = 7'h78;
            4'd8:    segCode = 7'h00;
            4'd9:    segCode = 7'h10;
            default: segCode = SEG_BLANK;
        endcase
    endfunction

    // Negating at WORD_W+1 bits keeps the most negative input representable.
    always_comb begin
        w_negative = signed_mode & value[WORD_W-1];
        w_magWide  = w_negative ? ({1'b0, ~value} + (WORD_W+1)'(1)) : {1'b0, value};
    end

    always_comb begin
        w_adjBcd = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adjBcd[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_bitCount <= '0;
            r_sign     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_disp0    <= SEG_ZERO;
            r_disp1    <= SEG_BLANK;
            r_disp2    <= SEG_BLANK;
            r_disp3    <= SEG_BLANK;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (load) begin
                        // Pre-shifted so the bit entering the BCD is always the top bit.
                        r_mag      <= w_magWide << 1;
                        r_sign     <= w_negative;
                        r_bcd      <= '0;
                        r_bitCount <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd      <= (w_adjBcd << 1) | {11'b0, r_mag[WORD_W]};
                    r_mag      <= r_mag << 1;
                    r_bitCount <= r_bitCount + CNT_W'(1);
                    if (r_bitCount == CNT_W'(WORD_W - 1)) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_disp0 <= segCode(r_bcd[3:0]);
                    r_disp1 <= (r_bcd[11:4] == 8'd0) ? SEG_BLANK : segCode(r_bcd[7:4]);
                    r_disp2 <= (r_bcd[11:8] == 4'd0) ? SEG_BLANK : segCode(r_bcd[11:8]);
                    r_disp3 <= r_sign ? SEG_MINUS : SEG_BLANK;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign disp0 = r_disp0;
    assign disp1 = r_disp1;
    assign disp2 = r_disp2;
    assign disp3 = r_disp3;

endmodule

// File: tb/tb_seg_display_driver.sv
// Drives directed and random conversions into seg_display_driver and compares
// busy/done timing and display codes against a decimal-arithmetic reference model.
module tb_seg_display_driver;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         load;
    logic [W-1:0] value;
    logic         signed_mode;
    logic         busy;
    logic         done;
    logic [6:0]   disp0;
    logic [6:0]   disp1;
    logic [6:0]   disp2;
    logic [6:0]   disp3;

    int passCount = 0;
    int failCount = 0;
    int totalCount = 0;

    logic [6:0]  segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [27:0] resetDisp = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    logic [27:0] expDisp;

    seg_display_driver #(.WORD_W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .disp0       (disp0),
        .disp1       (disp1),
        .disp2       (disp2),
        .disp3       (disp3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: decimal digits by division, sign by comparing to the half range.
    function automatic logic [27:0] modelDisp(input int val, input bit sm);
        int  mag;
        int  h;
        int  t;
        int  u;
        bit  neg;
        neg = sm && (val >= (1 << (W - 1)));
        mag = neg ? (1 << W) - val : val;
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        return {neg ? 7'h3F : 7'h7F,
                (h == 0) ? 7'h7F : segTab[h],
                (h == 0 && t == 0) ? 7'h7F : segTab[t],
                segTab[u]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount = totalCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dispNow();
        return {4'h0, disp3, disp2, disp1, disp0};
    endfunction

    // One full conversion; optionally fires a second load while busy, which must be dropped.
    task automatic applyStimulus(input int val, input bit sm, input bit extraLoad);
        logic [27:0] newDisp;
        newDisp = modelDisp(val, sm);
        @(negedge clock);
        load        = 1'b1;
        value       = W'(val);
        signed_mode = sm;
        @(posedge clock);
        @(negedge clock);
        load = 1'b0;
        checkOutput("busy_after_load", {31'b0, busy}, 32'd1);
        value       = W'($urandom);
        signed_mode = 1'($urandom);
        for (int i = 1; i <= W; i++) begin
            if (extraLoad && i == 2) begin
                load  = 1'b1;
                value = W'(42);
            end else begin
                load = 1'b0;
            end
            @(negedge clock);
            checkOutput("busy_during", {31'b0, busy}, 32'd1);
            checkOutput("done_during", {31'b0, done}, 32'd0);
            checkOutput("disp_held", dispNow(), {4'h0, expDisp});
        end
        load = 1'b0;
        @(negedge clock);
        checkOutput("done_pulse", {31'b0, done}, 32'd1);
        checkOutput("busy_end", {31'b0, busy}, 32'd0);
        checkOutput("disp_new", dispNow(), {4'h0, newDisp});
        expDisp = newDisp;
        @(negedge clock);
        checkOutput("done_single", {31'b0, done}, 32'd0);
        checkOutput("busy_idle", {31'b0, busy}, 32'd0);
        if (extraLoad) begin
            repeat (W + 2) begin
                @(negedge clock);
                checkOutput("dropped_no_done", {31'b0, done}, 32'd0);
                checkOutput("dropped_no_busy", {31'b0, busy}, 32'd0);
                checkOutput("dropped_disp", dispNow(), {4'h0, expDisp});
            end
        end
    endtask

    initial begin
        // Reset asserted together with load: reset must win.
        reset       = 1'b1;
        load        = 1'b1;
        value       = W'(173);
        signed_mode = 1'b0;
        expDisp     = resetDisp;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_disp", dispNow(), {4'h0, resetDisp});
        load  = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("idle_disp", dispNow(), {4'h0, resetDisp});

        $display("[TB] directed conversions");
        applyStimulus(173, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        applyStimulus(5, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(255, 1'b0, 1'b0);
        applyStimulus(8'h7F, 1'b1, 1'b0);
        applyStimulus(173, 1'b0, 1'b1);

        // Abort: reset lands on the 4th CONVERT edge.
        $display("[TB] reset abort");
        @(negedge clock);
        load        = 1'b1;
        value       = W'(200);
        signed_mode = 1'b0;
        @(posedge clock);
        @(negedge clock);
        load = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        expDisp = resetDisp;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_disp", dispNow(), {4'h0, resetDisp});
        repeat (W + 2) begin
            @(negedge clock);
            checkOutput("abort_no_done", {31'b0, done}, 32'd0);
            checkOutput("abort_disp_held", dispNow(), {4'h0, resetDisp});
        end
        applyStimulus(9, 1'b0, 1'b0);

        $display("[TB] random conversions");
        for (int n = 0; n < 24; n++) begin
            applyStimulus(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter WORD_W, default 8, width of the input data word; legal range 4..9.
REQ-002 Port clock, input, 1, system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, reset, synchronous, active-high.
REQ-004 Port load, input, 1, request to convert and display value; sampled only when busy=0.
REQ-005 Port value, input, WORD_W, word to display (CPU output data).
REQ-006 Port signed_mode, input, 1, 1 = value is two's complement, 0 = unsigned; sampled with load.
REQ-007 Port busy, output, 1, high while a conversion is in progress.
REQ-008 Port done, output, 1, one-cycle pulse when the displays update.
REQ-009 Ports disp0, disp1, disp2, disp3, output, 7 each, active-low segments; bit6=g ... bit0=a; disp0 = units, disp1 = tens, disp2 = hundreds, disp3 = sign.

Function
REQ-010 The block SHALL implement three states: IDLE, CONVERT, UPDATE.
REQ-011 IDLE with load=1: SHALL capture magnitude (|value| if signed_mode=1 and value MSB=1, else value), latch sign, clear the BCD shift register and bit counter, go to CONVERT.
REQ-012 IDLE with load=0: SHALL hold all outputs.
REQ-013 CONVERT: SHALL perform one double-dabble step per clock (add 3 to any BCD digit >= 5, then shift left one bit, MSB of magnitude into BCD); after exactly WORD_W steps, go to UPDATE.
REQ-014 UPDATE: SHALL register new disp0..disp3, assert done for that one cycle, go to IDLE.
REQ-015 busy SHALL be 1 in CONVERT and UPDATE, 0 in IDLE.
REQ-016 load while busy=1 SHALL be ignored (dropped, not queued); value and signed_mode changes while busy SHALL NOT affect the conversion in progress.
REQ-017 Latency: load sampled at edge k -> displays and done change after edge k+WORD_W+1; a new load is accepted at edge k+WORD_W+2 earliest.
REQ-018 Digit codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; blank=7F; minus=3F.
REQ-019 Leading-zero blanking: disp2 blank if hundreds=0; disp1 blank if hundreds=0 and tens=0; disp0 always shows its digit.
REQ-020 disp3 SHALL show minus when sign latched, else blank.
REQ-021 Magnitude SHALL be computed at WORD_W+1 bits so that the most negative value (e.g. -128) converts correctly.
REQ-022 disp outputs SHALL be registered; no output glitches during CONVERT (previous display held).

Reset
REQ-023 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, disp0=40, disp1=disp2=disp3=7F.
REQ-024 reset asserted during CONVERT or UPDATE SHALL abort the conversion; no done pulse; displays take reset values.
REQ-025 reset SHALL take priority over load in the same cycle.

Verification
REQ-026 reset pulse -> disp0=40, disp1/2/3=7F, busy=0, done=0.
REQ-027 load, value=173, signed_mode=0 -> after 10 edges: disp2=79, disp1=78, disp0=30, disp3=7F; done high one cycle; busy high 9 cycles.
REQ-028 load, value=8'h80, signed_mode=1 -> disp3=3F, disp2=79, disp1=24, disp0=00; then value=8'hFF signed -> disp3=3F, disp2=7F, disp1=7F, disp0=79.
REQ-029 load value=5 unsigned -> disp0=12, disp1=disp2=disp3=7F; then value=0 -> disp0=40, others 7F; then 255 -> 24,12,12.
REQ-030 load 173, then load 42 two cycles later -> second dropped; display shows 173, one done pulse only.
REQ-031 load 200, reset at 4th CONVERT cycle -> reset values next edge, no done; subsequent load 9 -> disp0=10.
